p88_loader: RTL and testbench

//  Parses a P88 program image streamed over the ioctl download port and turns it into RAM/ROM write strobes.

---
 rtl/p88_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_p88_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p88_loader.sv
// rtl/p88_loader.sv - P88 image parser turning the ioctl download stream into RAM/ROM write strobes.
// Optional running checksum of RAM data bytes is built only with P88_LOADER_CHECKSUM_EN defined.
module p88_loader #(
    parameter int ADDR_W     = 18,
    parameter int ROM_ADDR_W = 3
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [7:0]            ioctl_dout,
    output logic                  ioctl_wait,
    output logic                  hold_reset,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [7:0]            ram_dout,
    output logic                  ram_we,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [7:0]            rom_dout,
    output logic                  rom_we,
    output logic [15:0]           checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_SEC,
        S_DATA,
        S_ENT,
        S_ROM
    } state_t;

    state_t                  state_q;
    logic                    dl_q;
    logic                    hold_q;
    logic                    wait_q;
    logic [2:0]              cnt_q;
    logic [3:0]              step_q;
    logic [15:0]             seg_q;
    logic [15:0]             off_q;
    logic [15:0]             len_q;
    logic [ADDR_W-1:0]       ram_addr_q;
    logic [7:0]              ram_dout_q;
    logic                    ram_we_q;
    logic [ROM_ADDR_W-1:0]   rom_addr_q;
    logic [7:0]              rom_dout_q;
    logic                    rom_we_q;

    logic                    dl_rise_d;
    logic                    dl_fall_d;
    logic                    accept_d;
    logic [ADDR_W-1:0]       base_d;
    logic [15:0]             len_d;
    logic [7:0]              rom_next_d;

    assign dl_rise_d = ioctl_download & ~dl_q;
    assign dl_fall_d = ~ioctl_download & dl_q;
    assign accept_d  = ioctl_wr & ~wait_q & (state_q != S_IDLE);
    assign base_d    = ADDR_W'({seg_q, 4'h0}) + ADDR_W'(off_q);
    assign len_d     = {ioctl_dout, len_q[7:0]};

    // Far JMP image is EA, offL, offH, segL, segH; this picks the byte after rom_addr.
    always_comb begin
        rom_next_d = 8'h00;
        case (int'(rom_addr_q))
            0:       rom_next_d = off_q[7:0];
            1:       rom_next_d = off_q[15:8];
            2:       rom_next_d = seg_q[7:0];
            3:       rom_next_d = seg_q[15:8];
            default: rom_next_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dl_q       <= 1'b0;
            hold_q     <= 1'b0;
            wait_q     <= 1'b0;
            cnt_q      <= '0;
            step_q     <= '0;
            seg_q      <= '0;
            off_q      <= '0;
            len_q      <= '0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ram_we_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_dout_q <= '0;
            rom_we_q   <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise_d || dl_fall_d) begin
                hold_q   <= dl_rise_d;
                state_q  <= dl_rise_d ? S_CMD : S_IDLE;
                wait_q   <= 1'b0;
                ram_we_q <= 1'b0;
                rom_we_q <= 1'b0;
                step_q   <= '0;
                cnt_q    <= '0;
            end else begin
                case (state_q)
                    S_CMD: begin
                        if (accept_d && ioctl_dout == 8'hC8) begin
                            state_q <= S_SEC;
                            cnt_q   <= '0;
                        end else if (accept_d && ioctl_dout == 8'hCA) begin
                            state_q    <= S_ENT;
                            cnt_q      <= '0;
                            rom_addr_q <= '0;
                            rom_dout_q <= 8'hEA;
                        end
                    end
                    S_SEC: begin
                        if (accept_d) begin
                            cnt_q <= cnt_q + 3'd1;
                            case (cnt_q)
                                3'd0: seg_q[7:0]  <= ioctl_dout;
                                3'd1: seg_q[15:8] <= ioctl_dout;
                                3'd2: off_q[7:0]  <= ioctl_dout;
                                3'd3: off_q[15:8] <= ioctl_dout;
                                3'd6: len_q[7:0]  <= ioctl_dout;
                                3'd7: begin
                                    len_q      <= len_d;
                                    ram_addr_q <= base_d;
                                    step_q     <= '0;
                                    state_q    <= (len_d == 16'h0000) ? S_CMD : S_DATA;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_DATA: begin
                        // Three-cycle byte slot: strobe, advance, release the source.
                        case (step_q)
                            4'd0: begin
                                if (accept_d) begin
                                    ram_dout_q <= ioctl_dout;
                                    ram_we_q   <= 1'b1;
                                    wait_q     <= 1'b1;
                                    step_q     <= 4'd1;
                                end
                            end
                            4'd1: begin
                                ram_we_q   <= 1'b0;
                                ram_addr_q <= ram_addr_q + ADDR_W'(1);
                                len_q      <= len_q - 16'd1;
                                step_q     <= 4'd2;
                            end
                            default: begin
                                wait_q <= 1'b0;
                                step_q <= '0;
                                if (len_q == 16'h0000) state_q <= S_CMD;
                            end
                        endcase
                    end
                    S_ENT: begin
                        if (accept_d) begin
                            cnt_q <= cnt_q + 3'd1;
                            case (cnt_q)
                                3'd0: seg_q[7:0]  <= ioctl_dout;
                                3'd1: seg_q[15:8] <= ioctl_dout;
                                3'd2: off_q[7:0]  <= ioctl_dout;
                                default: begin
                                    off_q[15:8] <= ioctl_dout;
                                    state_q     <= S_ROM;
                                    wait_q      <= 1'b1;
                                    rom_we_q    <= 1'b1;
                                    step_q      <= '0;
                                end
                            endcase
                        end
                    end
                    S_ROM: begin
                        // Even steps are strobe cycles; odd steps are the gap that loads the next byte.
                        step_q <= step_q + 4'd1;
                        if (!step_q[0]) begin
                            rom_we_q <= 1'b0;
                            if (step_q != 4'd8) begin
                                rom_addr_q <= rom_addr_q + ROM_ADDR_W'(1);
                                rom_dout_q <= rom_next_d;
                            end
                        end else if (step_q != 4'd9) begin
                            rom_we_q <= 1'b1;
                        end else begin
                            wait_q  <= 1'b0;
                            step_q  <= '0;
                            state_q <= S_CMD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ioctl_wait = wait_q;
    assign hold_reset = hold_q;
    assign ram_addr   = ram_addr_q;
    assign ram_dout   = ram_dout_q;
    assign ram_we     = ram_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_dout   = rom_dout_q;
    assign rom_we     = rom_we_q;

`ifdef P88_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else if (dl_rise_d) begin
            checksum_q <= '0;
        end else if (ram_we_q) begin
            checksum_q <= checksum_q + {8'h00, ram_dout_q};
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_p88_loader.sv
// tb/tb_p88_loader.sv - scoreboard bench for p88_loader (expected RAM/ROM writes queued, monitor compares).
module tb_p88_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        hold_reset;
    logic [17:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [2:0]  rom_addr;
    logic [7:0]  rom_dout;
    logic        rom_we;
    logic [15:0] checksum;

    p88_loader #(.ADDR_W(18), .ROM_ADDR_W(3)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .hold_reset     (hold_reset),
        .ram_addr       (ram_addr),
        .ram_dout       (ram_dout),
        .ram_we         (ram_we),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .rom_we         (rom_we),
        .checksum       (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          rom;
        logic [17:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_ram(input logic [17:0] a, input logic [7:0] d);
        exp_t e;
        e.rom = 1'b0; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_rom(input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        e.rom = 1'b1; e.addr = {15'h0, a}; e.data = d;
        exp_q.push_back(e);
    endtask

    // Called on a negedge; returns on the negedge after the strobe cycle.
    task automatic send(input logic [7:0] b);
        int g = 0;
        while (ioctl_wait === 1'b1 && g < 100) begin
            @(negedge clk_sys);
            g++;
        end
        if (g >= 100) chk("send_wait_timeout", 32'(g), 32'd0);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (ioctl_wait === 1'b1 && g < 100) begin
            @(negedge clk_sys);
            g++;
        end
        if (g >= 100) chk("idle_timeout", 32'(g), 32'd0);
    endtask

    task automatic sec(input logic [15:0] seg, input logic [15:0] off, input logic [15:0] len);
        send(8'hC8);
        send(seg[7:0]); send(seg[15:8]);
        send(off[7:0]); send(off[15:8]);
        send(8'h00);    send(8'h00);
        send(len[7:0]); send(len[15:8]);
    endtask

    task automatic dl_start();
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk("hold_set", 32'(hold_reset), 32'd1);
        @(negedge clk_sys);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wait"},     32'(ioctl_wait), 32'd0);
        chk({tag, "_hold"},     32'(hold_reset), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr),   32'd0);
        chk({tag, "_ram_dout"}, 32'(ram_dout),   32'd0);
        chk({tag, "_ram_we"},   32'(ram_we),     32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr),   32'd0);
        chk({tag, "_rom_dout"}, 32'(rom_dout),   32'd0);
        chk({tag, "_rom_we"},   32'(rom_we),     32'd0);
        chk({tag, "_checksum"}, 32'(checksum),   32'd0);
    endtask

    always @(negedge clk_sys) begin
        if (reset_n && (ram_we || rom_we)) begin
            exp_t e;
            chk("we_exclusive", 32'(ram_we & rom_we), 32'd0);
            chk("strobe_in_hold", 32'(hold_reset), 32'd1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe ram_we=%0b rom_we=%0b ram_addr=%h rom_addr=%h", ram_we, rom_we, ram_addr, rom_addr);
            end else begin
                e = exp_q.pop_front();
                chk("write_kind_rom", 32'(rom_we), 32'(e.rom));
                if (e.rom) begin
                    chk("rom_addr", 32'(rom_addr), 32'(e.addr));
                    chk("rom_data", 32'(rom_dout), 32'(e.data));
                end else begin
                    chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                    chk("ram_data", 32'(ram_dout), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        logic [15:0] ck1;
        logic [15:0] ck2;
`ifdef P88_LOADER_CHECKSUM_EN
        ck1 = 16'h0066;
        ck2 = 16'h01DC;
`else
        ck1 = 16'h0000;
        ck2 = 16'h0000;
`endif
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_dout     = 8'h00;
        repeat (3) @(negedge clk_sys);
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk_sys);

        // 1: three-byte section at 0010:0004
        dl_start();
        push_ram(18'h00104, 8'h11);
        push_ram(18'h00105, 8'h22);
        push_ram(18'h00106, 8'h33);
        sec(16'h0010, 16'h0004, 16'h0003);
        send(8'h11); send(8'h22); send(8'h33);
        wait_idle();
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("t1_hold_clear", 32'(hold_reset), 32'd0);
        repeat (2) @(negedge clk_sys);
        chk("t1_checksum", 32'(checksum), 32'(ck1));

        // 2: entry record -> far JMP F000:1234
        dl_start();
        push_rom(3'd0, 8'hEA);
        push_rom(3'd1, 8'h34);
        push_rom(3'd2, 8'h12);
        push_rom(3'd3, 8'h00);
        push_rom(3'd4, 8'hF0);
        send(8'hCA); send(8'h00); send(8'hF0); send(8'h34); send(8'h12);
        wc = 0;
        while (ioctl_wait === 1'b1 && wc < 40) begin
            wc++;
            @(negedge clk_sys);
        end
        chk("t2_wait_cycles", 32'(wc), 32'd10);

        // 3: FFFF:0010 wraps to 0
        push_ram(18'h00000, 8'hAA);
        push_ram(18'h00001, 8'hBB);
        sec(16'hFFFF, 16'h0010, 16'h0002);
        send(8'hAA); send(8'hBB);
        wait_idle();

        // 4: empty section, stray byte, then a normal section
        sec(16'h0200, 16'h0000, 16'h0000);
        send(8'h5A);
        push_ram(18'h02005, 8'h77);
        sec(16'h0200, 16'h0005, 16'h0001);
        send(8'h77);
        wait_idle();
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("t4_checksum", 32'(checksum), 32'(ck2));

        // 5: abort after first of three data bytes
        dl_start();
        push_ram(18'h00300, 8'h01);
        sec(16'h0030, 16'h0000, 16'h0003);
        send(8'h01);
        wait_idle();
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("t5_hold_clear", 32'(hold_reset), 32'd0);
        ioctl_wr   = 1'b1;
        ioctl_dout = 8'h02;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        repeat (3) @(negedge clk_sys);
        dl_start();
        push_ram(18'h00301, 8'h05);
        sec(16'h0030, 16'h0001, 16'h0001);
        send(8'h05);
        wait_idle();
        chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);

        // 6: strobe during wait is dropped; reset mid ROM sequence
        dl_start();
        push_ram(18'h00500, 8'h99);
        sec(16'h0050, 16'h0000, 16'h0001);
        send(8'h99);
        chk("t6_wait_busy", 32'(ioctl_wait), 32'd1);
        ioctl_wr   = 1'b1;
        ioctl_dout = 8'hEE;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        push_rom(3'd0, 8'hEA);
        push_rom(3'd1, 8'h02);
        send(8'hCA); send(8'h01); send(8'h00); send(8'h02); send(8'h00);
        @(negedge clk_sys);
        @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("t6_inreset");
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk_zero("t6_held");
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("t6_hold_after", 32'(hold_reset), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
